mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache fill path and the data-cache fill/write-back path of the pipelined MIPS core.
- Sits between both cache controllers and the off-chip memory model.
- Serialises transactions, holds the memory command stable until the memory acknowledges, and returns a one-cycle ready to the owning cache.
- Bounds instruction-fetch starvation while the data side keeps priority.

Parameters:
ADDR_W, 28, line-granular address width (byte address [31:4])
DATA_W, 128, cache line width in bits
MAX_D_STREAK, 2, consecutive D grants allowed while I is pending before I is forced
TIMEOUT_CYC, 1023, cycles a transaction may wait for mem_ready (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_read  in  1  I-cache line-fill request
i_addr  in  ADDR_W  I-cache line address
i_rdata  out  DATA_W  fill data to I-cache
i_ready  out  1  I transaction complete, one-cycle pulse
d_read  in  1  D-cache line-fill request
d_write  in  1  D-cache write-back request
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  DATA_W  write-back data
d_rdata  out  DATA_W  fill data to D-cache
d_ready  out  1  D transaction complete, one-cycle pulse
mem_read  out  1  memory read command
mem_write  out  1  memory write command
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completion, one cycle
arb_err  out  1  sticky timeout flag

Behaviour:
- Reset, asynchronous: state IDLE; streak counter 0; arb_err 0; mem_read, mem_write, mem_addr and mem_wdata all 0.
- Reset mid-transaction aborts it. No ready pulse is issued.
- States:
  - IDLE: arbitrate on the current-cycle requests.
    - Winner is D if (d_read|d_write) and not (i_read and streak==MAX_D_STREAK); else I if i_read.
    - On the winning edge, register the command into mem_* and go to SERVE_D or SERVE_I.
    - A request present in IDLE at edge k produces a mem command during cycle k+1.
  - SERVE_I / SERVE_D:
    - mem_* held constant.
    - On a cycle with mem_ready=1: the owner's ready=1 combinationally in that cycle, and the owner's rdata=mem_rdata.
    - At that edge mem_read/mem_write clear and the state returns to IDLE.
    - Minimum one IDLE cycle between transactions.
- D command: d_write=1 issues mem_write with d_addr and d_wdata. This holds even if d_read is also 1; the read is served as a separate later request. d_read alone issues mem_read.
- Requester contract: hold req and addr/wdata stable until ready; drop req the cycle after ready. Requests and address changes while not granted are ignored until IDLE.
- Streak counter:
  - Increments on each D grant made while i_read=1, saturating at MAX_D_STREAK.
  - Clears on any I grant.
  - Clears on a D grant with i_read=0.
- i_rdata and d_rdata are 0 whenever their ready is 0.
- mem_ready outside SERVE is ignored.
- arb_err stays 0 without the optional feature.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in SERVE states and clears in IDLE.
  - When it reaches TIMEOUT_CYC without mem_ready, the arbiter pulses the owner's ready with rdata=0, sets arb_err until reset, and returns to IDLE.
  - mem_ready in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; waits indefinitely; arb_err tied 0.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding (IDLE=2'd0, SERVE_I=2'd1, SERVE_D=2'd2).
  - Default ADDR_W and DATA_W.
  - Owner IDs, which the cache controllers also use.
- One sub-module, mem_arb_timer: the timeout counter with clear/enable/expired, instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Reset release, idle: all outputs 0.
- i_read, addr 0x0000010, memory ready after 3 cycles → mem_read with mem_addr=0x0000010 from cycle 1, i_ready pulse in cycle 4 with i_rdata=mem_rdata.
- i_read and d_read held continuously with 1-cycle memory → grant order D,D,I,D,D,I; streak never exceeds 2.
- d_read and d_write both 1, addr 0x00000A0 → mem_write with d_wdata first; after d_ready with d_write dropped, the following mem_read at 0x00000A0.
- rst_n low during SERVE_D → mem_write and mem_read drop to 0 immediately; no d_ready; after release, a fresh I request is granted normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=8 and memory never ready → i_ready pulse at cycle 9 after the command, i_rdata=0, arb_err=1 until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter and the cache controllers using it.
// State encoding, default bus widths and requester owner IDs.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // Which requester owns the memory port in a given arbiter state.
  function automatic owner_e state_owner(input arb_state_e s);
    return (s == SERVE_D) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Main-memory command/response port: arbiter drives the command, memory answers.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Transaction timeout counter; only used when the arbiter is built with ARB_TIMEOUT_EN.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // Counts serve cycles and parks at LIMIT so the expiry stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = enable && (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache fills and D-cache fills/write-backs.
// Optional build macro ARB_TIMEOUT_EN adds a per-transaction timeout with a sticky arb_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MAX_D_STREAK = 2,
  parameter int unsigned TIMEOUT_CYC  = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  mem_arb_if.master         mem,
  output logic              arb_err
);

  localparam int unsigned STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  arb_state_e          state;
  logic [STREAK_W-1:0] streak;

  logic   d_req_c;
  logic   d_win_c;
  logic   streak_full_c;
  logic   serving_c;
  logic   mem_done_c;
  logic   expired_c;
  logic   done_c;
  owner_e owner_c;

  assign d_req_c       = d_read | d_write;
  assign streak_full_c = (streak == STREAK_W'(MAX_D_STREAK));
  // D keeps priority unless I has been passed over MAX_D_STREAK times in a row.
  assign d_win_c       = d_req_c && !(i_read && streak_full_c);
  assign serving_c     = (state == SERVE_I) || (state == SERVE_D);
  assign mem_done_c    = serving_c && mem.mem_ready;
  assign done_c        = mem_done_c || (serving_c && expired_c);
  assign owner_c       = state_owner(state);

  assign i_ready = done_c && (owner_c == OWNER_I);
  assign d_ready = done_c && (owner_c == OWNER_D);
  assign i_rdata = (mem_done_c && (owner_c == OWNER_I)) ? mem.mem_rdata : '0;
  assign d_rdata = (mem_done_c && (owner_c == OWNER_D)) ? mem.mem_rdata : '0;

  // Grant, command register and streak tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      streak        <= '0;
      mem.mem_read  <= 1'b0;
      mem.mem_write <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_win_c) begin
            // A write-back takes precedence over a simultaneous fill from the D side.
            state         <= SERVE_D;
            mem.mem_write <= d_write;
            mem.mem_read  <= !d_write;
            mem.mem_addr  <= d_addr;
            mem.mem_wdata <= d_write ? d_wdata : '0;
            if (!i_read) begin
              streak <= '0;
            end else if (!streak_full_c) begin
              streak <= streak + STREAK_W'(1);
            end
          end else if (i_read) begin
            state         <= SERVE_I;
            mem.mem_read  <= 1'b1;
            mem.mem_write <= 1'b0;
            mem.mem_addr  <= i_addr;
            mem.mem_wdata <= '0;
            streak        <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (done_c) begin
            state         <= IDLE;
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          mem.mem_read  <= 1'b0;
          mem.mem_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic err_q;

  mem_arb_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (!serving_c),
    .enable    (serving_c),
    .expired_c (expired_c)
  );

  // A completing mem_ready in the expiry cycle is a normal finish, not an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (serving_c && expired_c && !mem.mem_ready) begin
      err_q <= 1'b1;
    end
  end

  assign arb_err = err_q;
`else
  logic unused_timeout;

  assign expired_c      = 1'b0;
  assign arb_err        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory with programmable latency,
// expected transactions queued at request time and checked at command and ready.
module tb_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 1023;
`endif

  typedef struct {
    bit            is_d;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          arb_err;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  int mem_lat     = 0;
  bit mem_hang    = 1'b0;
  bit stray_ready = 1'b0;
  int busy        = 0;

  mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(2), .TIMEOUT_CYC(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem(mif), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
    return {32'hC0DE_0000 ^ 32'(a), 32'(a) * 32'd3, ~32'(a), 32'(a) + 32'h1111_1111};
  endfunction

  function automatic void push_exp(input bit is_d, input bit wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] w);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = w; e.rdata = line_data(a);
    sb.push_back(e);
  endfunction

  // Behavioural memory: answers mem_lat cycles after a command first appears.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0;
      mif.mem_ready = 1'b0;
      mif.mem_rdata = '0;
    end else begin
      mif.mem_ready = 1'b0;
      mif.mem_rdata = '0;
      if (mif.mem_read || mif.mem_write) begin
        if (!mem_hang && busy == mem_lat) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = line_data(mif.mem_addr);
          busy = 0;
        end else begin
          busy++;
        end
      end else begin
        busy = 0;
        if (stray_ready) begin
          mif.mem_ready = 1'b1;
          mif.mem_rdata = line_data(28'h123);
        end
      end
    end
  end

  // Runs queued transactions to completion, checking each command and each ready.
  task automatic drain(input string tag, input int max_cyc);
    logic cmd_prev;
    exp_t e;
    int   cyc;
    cmd_prev = mif.mem_read | mif.mem_write;
    cyc = 0;
    while (sb.size() != 0 && cyc < max_cyc) begin
      @(negedge clk); #1; cyc++;
      if ((mif.mem_read | mif.mem_write) && !cmd_prev) begin
        e = sb[0];
        n_cmp++;
        if ({mif.mem_write, mif.mem_read, mif.mem_addr} !== {e.wr, ~e.wr, e.addr}) begin
          n_err++;
          $display("FAIL %s_cmd got w=%b r=%b a=%h exp w=%b a=%h", tag, mif.mem_write,
                   mif.mem_read, mif.mem_addr, e.wr, e.addr);
        end
        if (e.wr) begin
          n_cmp++;
          if (mif.mem_wdata !== e.wdata) begin
            n_err++;
            $display("FAIL %s_wdata got %h exp %h", tag, mif.mem_wdata, e.wdata);
          end
        end
      end
      cmd_prev = mif.mem_read | mif.mem_write;
      if (i_ready || d_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if ({d_ready, i_ready} !== {e.is_d, ~e.is_d} ||
            (e.is_d ? d_rdata : i_rdata) !== e.rdata ||
            (e.is_d ? i_rdata : d_rdata) !== '0) begin
          n_err++;
          $display("FAIL %s_ready got d=%b i=%b drd=%h ird=%h exp d=%b rd=%h", tag, d_ready,
                   i_ready, d_rdata, i_rdata, e.is_d, e.rdata);
        end
        if (i_ready) i_read = 1'b0;
        if (d_ready) begin
          if (d_write) d_write = 1'b0;
          else d_read = 1'b0;
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout got %0d pending exp 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({mif.mem_read, mif.mem_write, i_ready, d_ready, arb_err} !== 5'b0 ||
        mif.mem_addr !== '0 || mif.mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_asserted got r=%b w=%b a=%h err=%b exp 0", mif.mem_read,
               mif.mem_write, mif.mem_addr, arb_err);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({mif.mem_read, mif.mem_write, i_ready, d_ready, arb_err} !== 5'b0 ||
        i_rdata !== '0 || d_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_idle got r=%b w=%b ir=%b dr=%b err=%b exp 0", mif.mem_read,
               mif.mem_write, i_ready, d_ready, arb_err);
    end
    // mem_ready while idle must not produce a ready or data.
    stray_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({i_ready, d_ready, mif.mem_read} !== 3'b0 || i_rdata !== '0 || d_rdata !== '0) begin
        n_err++;
        $display("FAIL stray_ready got ir=%b dr=%b r=%b exp 0", i_ready, d_ready, mif.mem_read);
      end
    end
    stray_ready = 1'b0;
  endtask

  task automatic test_single_i();
    exp_t e;
    mem_lat = 3;
    i_read = 1'b1;
    i_addr = 28'h0000010;
    push_exp(1'b0, 1'b0, i_addr, '0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (mif.mem_read !== (c <= 4) || i_ready !== (c == 4) || d_ready !== 1'b0 ||
          (c <= 4 && mif.mem_addr !== 28'h0000010)) begin
        n_err++;
        $display("FAIL single_i_c%0d got r=%b a=%h ir=%b exp r=%b ir=%b", c, mif.mem_read,
                 mif.mem_addr, i_ready, (c <= 4), (c == 4));
      end
      if (i_ready) begin
        e = sb.pop_front();
        n_cmp++;
        if (i_rdata !== e.rdata) begin
          n_err++;
          $display("FAIL single_i_rdata got %h exp %h", i_rdata, e.rdata);
        end
        i_read = 1'b0;
      end else if (i_rdata !== '0) begin
        n_cmp++;
        n_err++;
        $display("FAIL single_i_rdata_idle got %h exp 0", i_rdata);
      end
    end
    sb.delete();
  endtask

  // Both sides requesting continuously: D,D,I,D,D,I with one idle cycle between grants.
  task automatic test_streak();
    bit ord[$];
    bit is_d;
    ord = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    mem_lat = 0;
    i_read = 1'b1; i_addr = 28'h0000040;
    d_read = 1'b1; d_addr = 28'h0000080;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (mif.mem_read !== (c % 2 == 1 && c <= 11)) begin
        n_err++;
        $display("FAIL streak_busy_c%0d got %b exp %b", c, mif.mem_read, (c % 2 == 1));
      end
      if (c % 2 == 1 && ord.size() != 0) begin
        is_d = ord.pop_front();
        n_cmp++;
        if ({d_ready, i_ready} !== {is_d, ~is_d} ||
            mif.mem_addr !== (is_d ? 28'h0000080 : 28'h0000040) ||
            (is_d ? d_rdata : i_rdata) !== line_data(mif.mem_addr)) begin
          n_err++;
          $display("FAIL streak_grant_c%0d got d=%b i=%b a=%h exp d=%b", c, d_ready, i_ready,
                   mif.mem_addr, is_d);
        end
        if (c == 11) begin
          i_read = 1'b0;
          d_read = 1'b0;
        end
      end
    end
  endtask

  task automatic test_rw_same();
    logic [DW-1:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem_lat = 1;
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h00000A0; d_wdata = w;
    push_exp(1'b1, 1'b1, d_addr, w);
    push_exp(1'b1, 1'b0, d_addr, '0);
    drain("rw_same", 30);
  endtask

  task automatic test_mixed();
    logic [DW-1:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    mem_lat = 2;
    i_read = 1'b1; i_addr = 28'h0ABCDE0;
    d_write = 1'b1; d_addr = 28'h0123450; d_wdata = w;
    push_exp(1'b1, 1'b1, d_addr, w);
    push_exp(1'b0, 1'b0, i_addr, '0);
    drain("mixed", 30);
  endtask

  task automatic test_reset_mid();
    bit seen;
    mem_hang = 1'b1;
    d_write = 1'b1; d_addr = 28'h0000033;
    d_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk); #1;
      if (mif.mem_write) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL reset_mid_grant got no mem_write exp mem_write");
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    d_write = 1'b0;
    #1;
    n_cmp++;
    if ({mif.mem_write, mif.mem_read, d_ready, i_ready} !== 4'b0 || mif.mem_addr !== '0) begin
      n_err++;
      $display("FAIL reset_mid_abort got w=%b r=%b dr=%b a=%h exp 0", mif.mem_write,
               mif.mem_read, d_ready, mif.mem_addr);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    mem_hang = 1'b0;
    mem_lat = 0;
    @(negedge clk); #1;
    n_cmp++;
    if ({d_ready, i_ready, mif.mem_write, mif.mem_read, arb_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle got dr=%b w=%b err=%b exp 0", d_ready, mif.mem_write,
               arb_err);
    end
    i_read = 1'b1; i_addr = 28'h0000077;
    push_exp(1'b0, 1'b0, i_addr, '0);
    drain("reset_mid_i", 20);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    mem_hang = 1'b1;
    i_read = 1'b1; i_addr = 28'h0000055;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (i_ready !== (c == 9) || i_rdata !== '0 || arb_err !== (c >= 10)) begin
        n_err++;
        $display("FAIL timeout_c%0d got ir=%b rd=%h err=%b exp ir=%b err=%b", c, i_ready,
                 i_rdata, arb_err, (c == 9), (c >= 10));
      end
      if (i_ready) i_read = 1'b0;
    end
    mem_hang = 1'b0;
    mem_lat = 1;
    d_read = 1'b1; d_addr = 28'h0000066;
    push_exp(1'b1, 1'b0, d_addr, '0);
    drain("after_timeout", 20);
    n_cmp++;
    if (arb_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky got %b exp 1", arb_err);
    end
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (arb_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_reset got %b exp 0", arb_err);
    end
    @(negedge clk); #1 rst_n = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    bit bad;
    mem_hang = 1'b1;
    i_read = 1'b1; i_addr = 28'h0000005;
    bad = 1'b0;
    @(negedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (i_ready || !mif.mem_read || arb_err) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL no_timeout got early ready/err exp wait");
    end
    i_read = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    mem_hang = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_i();
    test_streak();
    test_rw_same();
    test_mixed();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
